// File: rtl/alu_ctrl_pipe_if.sv
// EX-stage ALU control bus: ID/EX handshake and decode inputs, and the
// registered ALU control plus MULT/DIV sequencing outputs.
interface alu_ctrl_pipe_if;
    logic       in_valid;
    logic [5:0] funct;
    logic [2:0] ALUOp;
    logic       stall;
    logic       flush;
    logic       in_ready;
    logic [3:0] ALUsignal;
    logic       out_valid;
    logic       illegal;
    logic       md_start;
    logic       busy;
    logic       hilo_we;

    // Pipeline side that presents instructions and consumes ALU control.
    modport master (
        output in_valid, funct, ALUOp, stall, flush,
        input  in_ready, ALUsignal, out_valid, illegal, md_start, busy, hilo_we
    );

    // ALU control block.
    modport slave (
        input  in_valid, funct, ALUOp, stall, flush,
        output in_ready, ALUsignal, out_valid, illegal, md_start, busy, hilo_we
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder for the EX stage. Decodes ALUOp/funct into
// ALUsignal with valid/ready handshaking, honours stall and flush, and runs a
// busy counter for multi-cycle MULT/DIV with a HI/LO write pulse at the end.
module alu_ctrl_pipe #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic           clk,
    input  logic           rst,
    alu_ctrl_pipe_if.slave bus
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MD_BUSY = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_MULT = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_signal_q, alu_signal_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic             md_start_q, md_start_d;

    logic [3:0] dec_sig;
    logic       dec_ill;
    logic       dec_mul;
    logic       dec_div;
    logic       busy;
    logic       in_ready;
    logic       accept;

    assign busy     = (state_q == S_MD_BUSY);
    assign in_ready = ~busy & ~bus.stall;
    assign accept   = bus.in_valid & in_ready & ~bus.flush;

    // Decode the ALUOp class, falling through to the funct table for R-type.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_sig = OP_ILL;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        unique case (bus.ALUOp)
            3'b000: dec_sig = OP_ADD;
            3'b001: dec_sig = OP_SUB;
            3'b011: dec_sig = OP_AND;
            3'b100: dec_sig = OP_OR;
            3'b101: dec_sig = OP_SLT;
            3'b110: dec_sig = OP_XOR;
            3'b111: dec_ill = 1'b1;
            3'b010: begin
                case (bus.funct)
                    6'b100000, 6'b100001: dec_sig = OP_ADD;
                    6'b100010, 6'b100011: dec_sig = OP_SUB;
                    6'b100100:            dec_sig = OP_AND;
                    6'b100101:            dec_sig = OP_OR;
                    6'b100110:            dec_sig = OP_XOR;
                    6'b100111:            dec_sig = OP_NOR;
                    6'b101010, 6'b101011: dec_sig = OP_SLT;
                    6'b000000:            dec_sig = OP_SLL;
                    6'b000010:            dec_sig = OP_SRL;
                    6'b000011:            dec_sig = OP_SRA;
                    6'b011000, 6'b011001: begin dec_sig = OP_MULT; dec_mul = 1'b1; end
                    6'b011010, 6'b011011: begin dec_sig = OP_DIV;  dec_div = 1'b1; end
                    default:              dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Next-state: flush beats stall beats accept; the busy counter runs through stalls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_signal_d = alu_signal_q;
        out_valid_d  = out_valid_q;
        illegal_d    = illegal_q;
        md_start_d   = 1'b0;

        if (state_q == S_MD_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
            end
        end

        if (bus.flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (bus.stall) begin
            // Outputs hold; only the busy counter above advances.
        end else if (accept) begin
            alu_signal_d = dec_sig;
            out_valid_d  = 1'b1;
            illegal_d    = dec_ill;
            if (dec_mul || dec_div) begin
                state_d    = S_MD_BUSY;
                cnt_d      = dec_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                md_start_d = 1'b1;
            end
        end else begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_signal_q <= OP_AND;
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            md_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_signal_q <= alu_signal_d;
            out_valid_q  <= out_valid_d;
            illegal_q    <= illegal_d;
            md_start_q   <= md_start_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ALUsignal = alu_signal_q;
    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.md_start  = md_start_q;
    assign bus.busy      = busy;
    // Final busy cycle writes HI/LO unless this same cycle aborts the operation.
    assign bus.hilo_we   = busy & (cnt_q == CNT_W'(1)) & ~bus.flush & ~rst;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios followed by
// random traffic, compared against a cycle-indexed reference model.
module tb_alu_ctrl_pipe;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_ctrl_pipe_if bus ();

    alu_ctrl_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle number and the cycle at which busy ends.
    int         cyc    = 0;
    int         md_end = -1;
    logic [3:0] m_sig   = 4'b0000;
    logic       m_valid = 1'b0;
    logic       m_ill   = 1'b0;
    logic       m_start = 1'b0;

    logic [5:0] legal_fn [0:18] = '{
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
        6'b000011, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b100000,
        6'b011000
    };

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Spec decode table: returns code, illegal flag, and MD latency (0 = single cycle).
    task automatic ref_decode(input logic [2:0] op, input logic [5:0] fn,
                              output logic [3:0] sig, output logic ill, output int lat);
        ill = 1'b0;
        lat = 0;
        sig = 4'b1111;
        case (op)
            3'd0: sig = 4'b0010;
            3'd1: sig = 4'b0110;
            3'd3: sig = 4'b0000;
            3'd4: sig = 4'b0001;
            3'd5: sig = 4'b0111;
            3'd6: sig = 4'b0011;
            3'd7: ill = 1'b1;
            default: begin
                if (fn == 6'd32 || fn == 6'd33)      sig = 4'b0010;
                else if (fn == 6'd34 || fn == 6'd35) sig = 4'b0110;
                else if (fn == 6'd36)                sig = 4'b0000;
                else if (fn == 6'd37)                sig = 4'b0001;
                else if (fn == 6'd38)                sig = 4'b0011;
                else if (fn == 6'd39)                sig = 4'b1100;
                else if (fn == 6'd42 || fn == 6'd43) sig = 4'b0111;
                else if (fn == 6'd0)                 sig = 4'b1000;
                else if (fn == 6'd2)                 sig = 4'b1001;
                else if (fn == 6'd3)                 sig = 4'b1010;
                else if (fn == 6'd24 || fn == 6'd25) begin sig = 4'b0100; lat = MUL_LAT; end
                else if (fn == 6'd26 || fn == 6'd27) begin sig = 4'b0101; lat = DIV_LAT; end
                else                                 ill = 1'b1;
            end
        endcase
        if (ill) sig = 4'b1111;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, update model, check registers.
    task automatic step(input logic v, input logic [2:0] op, input logic [5:0] fn,
                        input logic st, input logic fl, input logic r);
        logic       exp_busy, exp_ready, exp_hilo, acc, ill;
        logic [3:0] sig;
        int         lat;
        bus.in_valid = v;
        bus.ALUOp    = op;
        bus.funct    = fn;
        bus.stall    = st;
        bus.flush    = fl;
        rst          = r;
        #1;
        exp_busy  = (cyc < md_end);
        exp_ready = !exp_busy && !st;
        exp_hilo  = exp_busy && (cyc == md_end - 1) && !fl && !r;
        check("in_ready", {3'b0, bus.in_ready}, {3'b0, exp_ready});
        check("hilo_we",  {3'b0, bus.hilo_we},  {3'b0, exp_hilo});
        acc = v && exp_ready && !fl && !r;
        ref_decode(op, fn, sig, ill, lat);
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            m_sig = 4'b0000; m_valid = 1'b0; m_ill = 1'b0; m_start = 1'b0; md_end = -1;
        end else if (fl) begin
            m_valid = 1'b0; m_ill = 1'b0; m_start = 1'b0; md_end = -1;
        end else if (st) begin
            m_start = 1'b0;
        end else if (acc) begin
            m_sig = sig; m_valid = 1'b1; m_ill = ill; m_start = (lat != 0);
            if (lat != 0) md_end = cyc + lat;
        end else begin
            m_valid = 1'b0; m_ill = 1'b0; m_start = 1'b0;
        end
        check("ALUsignal", bus.ALUsignal, m_sig);
        check("out_valid", {3'b0, bus.out_valid}, {3'b0, m_valid});
        check("illegal",   {3'b0, bus.illegal},   {3'b0, m_ill});
        check("md_start",  {3'b0, bus.md_start},  {3'b0, m_start});
        check("busy",      {3'b0, bus.busy},      {3'b0, cyc < md_end});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 6'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        bus.in_valid = 1'b0;
        bus.ALUOp    = 3'b000;
        bus.funct    = 6'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        // Unchecked first edge clears X state; afterwards every cycle is checked.
        @(posedge clk);
        #1;
        step(1'b0, 3'b000, 6'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 6'b0, 1'b0, 1'b0, 1'b0);

        // R-type ADD.
        step(1'b1, 3'b010, 6'b100000, 1'b0, 1'b0, 1'b0);

        // Non-R-type back-to-back stream.
        step(1'b1, 3'b000, 6'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b001, 6'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 6'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b110, 6'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // MULT, with an ADD presented continuously until it is accepted.
        pulses = 0;
        step(1'b1, 3'b010, 6'b011000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MUL_LAT + 1; i++) begin
            if (bus.hilo_we) pulses++;
            step(1'b1, 3'b000, 6'b0, 1'b0, 1'b0, 1'b0);
        end
        check("mult_hilo_pulses", 4'(pulses), 4'd1);
        idle(1);

        // DIV aborted by flush on busy cycle 10.
        step(1'b1, 3'b010, 6'b011010, 1'b0, 1'b0, 1'b0);
        idle(9);
        step(1'b0, 3'b000, 6'b0, 1'b0, 1'b1, 1'b0);
        idle(DIV_LAT);

        // Illegal, then a stalled valid input that is accepted on release.
        step(1'b1, 3'b111, 6'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b101, 6'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'b101, 6'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Reset on busy cycle 2 of a MULT.
        step(1'b1, 3'b010, 6'b011001, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 3'b000, 6'b0, 1'b0, 1'b0, 1'b1);
        idle(MUL_LAT + 1);

        // Flush arriving on the final busy cycle of a MULT.
        step(1'b1, 3'b010, 6'b011000, 1'b0, 1'b0, 1'b0);
        idle(MUL_LAT - 1);
        step(1'b0, 3'b000, 6'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] fn;
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 18)];
            step(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom),
                 fn,
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 79) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Registered, pipelined successor to the combinational ALU control decoder in the pipelined processor's EX stage. Decodes `ALUOp`/`funct` into a registered `ALUsignal` with valid/ready handshaking, honours pipeline stall and flush, and sequences multi-cycle MULT/DIV operations. During a multi-cycle operation it holds off the ID/EX stage and pulses the HI/LO write enable on completion.

## Interface
- `MUL_LAT`, default 4: busy cycles for MULT/MULTU (≥1).
- `DIV_LAT`, default 32: busy cycles for DIV/DIVU (≥1).
- `CNT_W`, default 6: busy counter width; must hold max(MUL_LAT, DIV_LAT).
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: ID/EX presents an instruction.
- `funct`  in  6: R-type function field.
- `ALUOp`  in  3: main-control ALU operation class.
- `stall`  in  1: downstream hazard stall; output registers hold.
- `flush`  in  1: branch/exception flush of the EX slot.
- `in_ready`  out  1: combinational, `~busy & ~stall`.
- `ALUsignal`  out  4: registered ALU operation code.
- `out_valid`  out  1: `ALUsignal` is valid for the current EX slot.
- `illegal`  out  1: registered; decoded instruction is unsupported.
- `md_start`  out  1: one-cycle pulse that starts the MULT/DIV datapath.
- `busy`  out  1: a multi-cycle operation is in progress.
- `hilo_we`  out  1: one-cycle HI/LO write enable at completion.

## Operation
- **ALUOp decode:**
  - 000 → ADD 0010
  - 001 → SUB 0110
  - 010 → decode `funct`
  - 011 → AND 0000
  - 100 → OR 0001
  - 101 → SLT 0111
  - 110 → XOR 0011
  - 111 → illegal
- **funct decode:**
  - 100000/100001 → 0010
  - 100010/100011 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 100110 → 0011
  - 100111 → NOR 1100
  - 101010/101011 → 0111
  - 000000 → SLL 1000
  - 000010 → SRL 1001
  - 000011 → SRA 1010
  - 011000/011001 → MULT 0100
  - 011010/011011 → DIV 0101
  - any other value → illegal
- **Illegal:** `ALUsignal`=1111, `illegal`=1, `out_valid`=1, no `md_start`.
- **Accept:** an instruction is accepted when `in_valid & in_ready & ~flush`.
- **FSM, IDLE → MD_BUSY:** an accepted MULT/DIV loads `cnt` with MUL_LAT or DIV_LAT respectively, sets `busy`, and pulses `md_start`.
- **FSM, MD_BUSY:** `cnt` decrements each cycle. Remaining busy cycles are not frozen by `stall`.
- **FSM, MD_BUSY → IDLE:** `hilo_we`=1 in the cycle where `cnt`==1. `busy` clears on the following edge.
- **Priority:** `rst` > `flush` > `stall` > accept.
- **Flush in IDLE:** `out_valid`←0 and `illegal`←0. A same-cycle `in_valid` is dropped.
- **Flush in MD_BUSY:** the operation is aborted: `cnt`←0, `busy`←0, and no `hilo_we` is issued. Flush on the `cnt`==1 cycle suppresses that cycle's `hilo_we`.
- **Stall (without flush):** `ALUsignal`, `out_valid` and `illegal` hold; no accept.
- **Idle cycle (no accept, no stall, no flush):** `out_valid`←0, `illegal`←0. `ALUsignal` holds its last value.
- **Reset mid-operation:** same effect as an abort; all outputs return to their reset values on the next edge.

## Timing
- **Reset values:**
  - `ALUsignal`=0000
  - `out_valid`=0
  - `illegal`=0
  - `md_start`=0
  - `busy`=0
  - `hilo_we`=0
  - `cnt`=0
  - FSM in IDLE
  - `in_ready`=1, provided `stall`=0
- **Single-cycle ops:** accepted at edge N; `ALUsignal`/`out_valid` are valid after edge N (1-cycle latency). Back-to-back accepts sustain one instruction per cycle.
- **MULT/DIV accepted at edge N:**
  - `md_start`, `busy` and `out_valid` are high from edge N, with `ALUsignal` set to the MD code.
  - `md_start` drops at N+1.
  - `hilo_we` is high during the cycle after edge N+LAT−1.
  - `busy` drops at edge N+LAT.
  - `in_ready` returns to 1 at N+LAT; the earliest next accept is edge N+LAT.
- **LAT=1:** `md_start` and `hilo_we` are high in the same cycle.
- **Output pulses:** `md_start` and `hilo_we` are never high for more than one cycle per operation.

## Test plan
- **Reset, then R-type ADD:** `ALUOp`=010, `funct`=100000, `in_valid`=1 → one edge later `ALUsignal`=0010, `out_valid`=1, `illegal`=0.
- **Non-R-type stream:** back-to-back `ALUOp`=000, 001, 100, 110 → `ALUsignal`=0010, 0110, 0001, 0011 on consecutive cycles; `in_ready` stays 1.
- **MULT with `MUL_LAT`=4:** `funct`=011000 accepted at edge N → `md_start` high for 1 cycle. `busy` and `in_ready`=0 for 4 cycles. Exactly one `hilo_we` pulse in the 4th busy cycle. Next ADD is accepted at N+4.
- **DIV aborted by flush:** DIV accepted, then `flush`=1 on busy cycle 10 → `busy`=0 and `out_valid`=0 next edge; no `hilo_we` ever; `in_ready`=1.
- **Illegal and stall:** `ALUOp`=111 → `ALUsignal`=1111, `illegal`=1. Then hold `stall`=1 for 3 cycles with a new valid input → `in_ready`=0, outputs unchanged, input not consumed. Releasing `stall` accepts the input.
- **Reset mid-MULT:** assert `rst` on busy cycle 2 → next edge all outputs at reset values, no `hilo_we`.
